// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter register slice.
//   - uart_state_e : transmit FSM states
//   - REG_*        : word register offsets on io_addr
//   - STAT_*       : bit positions inside the STATUS word
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int STAT_FULL      = 0;
  localparam int STAT_EMPTY     = 1;
  localparam int STAT_SHIFTING  = 2;
  localparam int STAT_OVERFLOW  = 3;
  localparam int STAT_COUNT_LSB = 4;
  localparam int STAT_COUNT_MSB = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word fall-through output.
// Ports:
//   clk, srst        : clock and synchronous active-high reset
//   push, din        : write request and data (ignored when full unless popping)
//   pop              : read request (ignored when empty); dout is the head entry
//   count            : number of stored entries, 0..DEPTH
//   full, empty      : derived from count so pointer equality never matters
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == (PTR_W+1)'(DEPTH));
  assign count = count_reg;
  assign dout  = mem[rd_ptr_reg];

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: 8N1 frames fed from a small FIFO.
// Ports:
//   clk, RESET          : clock and synchronous active-high reset
//   io_addr             : word index (0 DATA, 1 STATUS, 2/3 reserved)
//   io_wdata, io_wstrb  : write data (byte in [7:0]) and one-cycle strobe
//   io_rstrb, io_rdata  : one-cycle read strobe and registered read data
//   tx                  : serial line, idle high, driven from a flop
//   busy                : frame in progress or bytes still queued
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 104,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic [1:0]  io_addr,
  input  logic [31:0] io_wdata,
  input  logic        io_wstrb,
  input  logic        io_rstrb,
  output logic [31:0] io_rdata,
  output logic        tx,
  output logic        busy
);

  localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  uart_state_e      state_reg;
  logic [15:0]      baud_cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_data_reg;
  logic             tx_reg;
  logic             overflow_reg;
  logic [31:0]      rdata_reg;

  logic             fifo_push;
  logic             fifo_pop;
  logic [7:0]       fifo_dout;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  logic             wr_data;
  logic             rd_status;
  logic             overflow_set;
  logic             baud_done;
  logic [31:0]      status_word;
  logic             unused_wdata;

  assign unused_wdata = ^io_wdata[31:8];

  always_comb begin
    wr_data      = io_wstrb && !RESET && (io_addr == REG_DATA);
    rd_status    = io_rstrb && !RESET && (io_addr == REG_STATUS);
    fifo_pop     = !RESET && (state_reg == ST_IDLE) && !fifo_empty;
    // The IDLE pop frees a slot this very cycle, so a write to a full FIFO is kept.
    fifo_push    = wr_data && (!fifo_full || fifo_pop);
    overflow_set = wr_data && fifo_full && !fifo_pop;
    baud_done    = (baud_cnt_reg == BAUD_LAST);

    // Built from pre-edge state, so a simultaneous write is not yet visible.
    status_word                                 = '0;
    status_word[STAT_FULL]                      = fifo_full;
    status_word[STAT_EMPTY]                     = fifo_empty;
    status_word[STAT_SHIFTING]                  = (state_reg != ST_IDLE);
    status_word[STAT_OVERFLOW]                  = overflow_reg;
    status_word[STAT_COUNT_MSB:STAT_COUNT_LSB]  = 5'(fifo_count);
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .srst  (RESET),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (io_wdata[7:0]),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Transmit FSM. tx_reg is loaded on the same edge as each state/bit change,
  // so the line level lines up exactly with the state it belongs to.
  always_ff @(posedge clk) begin
    if (RESET) begin
      state_reg      <= ST_IDLE;
      baud_cnt_reg   <= '0;
      bit_idx_reg    <= '0;
      shift_data_reg <= '0;
      tx_reg         <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (fifo_pop) begin
            shift_data_reg <= fifo_dout;
            baud_cnt_reg   <= '0;
            tx_reg         <= 1'b0;
            state_reg      <= ST_START;
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            tx_reg       <= shift_data_reg[0];
            state_reg    <= ST_DATA;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            if (bit_idx_reg == 3'd7) begin
              tx_reg    <= 1'b1;
              state_reg <= ST_STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 3'd1;
              tx_reg      <= shift_data_reg[bit_idx_reg + 3'd1];
            end
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt_reg <= '0;
            state_reg    <= ST_IDLE;
          end else begin
            baud_cnt_reg <= baud_cnt_reg + 16'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Register interface: read data holds between reads; overflow is sticky
  // until a STATUS read, and a fresh overflow on that same edge is not lost.
  always_ff @(posedge clk) begin
    if (RESET) begin
      overflow_reg <= 1'b0;
      rdata_reg    <= '0;
    end else begin
      if (io_rstrb) begin
        rdata_reg <= rd_status ? status_word : '0;
      end
      if (overflow_set) begin
        overflow_reg <= 1'b1;
      end else if (rd_status) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign tx       = tx_reg;
  assign io_rdata = rdata_reg;
  assign busy     = (state_reg != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io (BAUD_DIV=4, FIFO_DEPTH=4): a frame-position model
// predicts tx/busy/io_rdata every cycle; directed scenarios add literal checks.
module tb_uart_tx_io;

  localparam int BAUD  = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * BAUD;

  logic        clk = 1'b0;
  logic        RESET;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic        io_wstrb;
  logic        io_rstrb;
  logic [31:0] io_rdata;
  logic        tx;
  logic        busy;

  uart_tx_io #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_wstrb (io_wstrb),
    .io_rstrb (io_rstrb),
    .io_rdata (io_rdata),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mpos = cycle index inside the current frame, -1 when no frame is on the line.
  logic [7:0]  mq[$];
  int          mpos = -1;
  logic [7:0]  mbyte = 8'h00;
  logic        movf = 1'b0;
  logic [31:0] mrdata = 32'h0;
  bit          model_live = 0;

  always @(posedge clk) begin : model
    int cnt;
    bit pop_now;
    logic [31:0] st;
    model_live = 1;
    if (RESET) begin
      mq.delete();
      mpos   = -1;
      movf   = 1'b0;
      mrdata = 32'h0;
    end else begin
      cnt     = mq.size();
      pop_now = (mpos < 0) && (cnt > 0);
      st = 32'((cnt == DEPTH) ? 1 : 0) + 32'((cnt == 0) ? 2 : 0)
         + 32'((mpos >= 0) ? 4 : 0) + 32'(movf ? 8 : 0) + 32'(cnt * 16);
      if (io_rstrb) begin
        mrdata = (io_addr == 2'd1) ? st : 32'h0;
        if (io_addr == 2'd1) movf = 1'b0;
      end
      if (mpos >= 0) begin
        mpos++;
        if (mpos == FRAME) mpos = -1;
      end else if (pop_now) begin
        mbyte = mq.pop_front();
        mpos  = 0;
      end
      if (io_wstrb && io_addr == 2'd0) begin
        if (cnt < DEPTH || pop_now) mq.push_back(io_wdata[7:0]);
        else movf = 1'b1;
      end
    end
  end

  function automatic logic model_tx();
    int b;
    if (mpos < 0) return 1'b1;
    b = mpos / BAUD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return mbyte[b-1];
  endfunction

  always @(negedge clk) begin
    if (model_live) begin
      chk("tx", 64'(tx), 64'(model_tx()));
      chk("busy", 64'(busy), 64'((mpos >= 0) || (mq.size() > 0)));
      chk("io_rdata", 64'(io_rdata), 64'(mrdata));
    end
  end

  // ---------------- line monitor: captures whole frames from tx ----------------
  logic [FRAME-1:0] cap_q[$];
  int               start_q[$];
  logic [FRAME-1:0] cap;
  int               cap_idx = 0;
  bit               capturing = 0;
  logic             prev_tx = 1'b1;
  int               cycle = 0;

  always @(negedge clk) begin
    cycle++;
    if (RESET) begin
      capturing = 0;
    end else if (capturing) begin
      cap[cap_idx] = tx;
      cap_idx++;
      if (cap_idx == FRAME) begin
        capturing = 0;
        cap_q.push_back(cap);
      end
    end else if (prev_tx === 1'b1 && tx === 1'b0) begin
      capturing = 1;
      cap       = '0;
      cap_idx   = 1;
      start_q.push_back(cycle);
    end
    prev_tx = tx;
  end

  function automatic logic [7:0] decode(input logic [FRAME-1:0] c);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = c[BAUD*(k+1) + BAUD/2];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input logic w, input logic r, input logic [1:0] a, input logic [7:0] d);
    io_wstrb = w;
    io_rstrb = r;
    io_addr  = a;
    io_wdata = {24'hA5A5A5, d};
    step();
    io_wstrb = 1'b0;
    io_rstrb = 1'b0;
    io_addr  = 2'd0;
    $display("[TB] t=%0t wstrb=%0b rstrb=%0b addr=%0d wdata=%02h rdata=%03h", $time, w, r, a, d, io_rdata[11:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  logic [7:0] exp_bytes [16] = '{8'h55, 8'hA1, 8'h00, 8'hFF, 8'h11, 8'h21, 8'h22, 8'h23,
                                 8'h24, 8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h3C, 8'h5A};

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    RESET = 1'b1; io_addr = 2'd0; io_wdata = 32'h0; io_wstrb = 1'b0; io_rstrb = 1'b0;
    // strobes during reset must be ignored
    @(posedge clk); #2;
    io_wstrb = 1'b1; io_rstrb = 1'b1; io_wdata = 32'h99;
    idle(2);
    io_wstrb = 1'b0; io_rstrb = 1'b0;
    RESET = 1'b0;
    chk("reset_rdata", 64'(io_rdata), 64'h0);
    chk("reset_tx", 64'(tx), 64'h1);
    chk("reset_busy", 64'(busy), 64'h0);

    // reserved / STATUS writes ignored, reserved and DATA reads return 0
    cyc(1, 0, 2'd2, 8'h77);
    cyc(1, 0, 2'd1, 8'h66);
    cyc(1, 0, 2'd3, 8'h88);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_idle", 64'(io_rdata), 64'h002);
    cyc(0, 1, 2'd3, 8'h00);
    chk("read_reserved", 64'(io_rdata), 64'h0);
    cyc(0, 1, 2'd1, 8'h00);
    cyc(0, 1, 2'd0, 8'h00);
    chk("read_data", 64'(io_rdata), 64'h0);
    idle(3);
    chk("no_frame_after_ignored_writes", 64'(busy), 64'h0);

    // single 0x55 frame
    cyc(1, 0, 2'd0, 8'h55);
    idle(50);
    chk("frame55_seen", 64'(cap_q.size()), 64'd1);
    if (cap_q.size() >= 1) chk("frame55_wave", 64'(cap_q[0]), 64'hF0F0F0F0F0);

    // three back-to-back frames
    cyc(1, 0, 2'd0, 8'hA1);
    cyc(1, 0, 2'd0, 8'h00);
    cyc(1, 0, 2'd0, 8'hFF);
    idle(3 * (FRAME + 1) + 10);
    chk("three_frames_seen", 64'(start_q.size()), 64'd4);
    if (start_q.size() >= 4) begin
      chk("gap_1_2", 64'(start_q[2] - start_q[1]), 64'd41);
      chk("gap_2_3", 64'(start_q[3] - start_q[2]), 64'd41);
    end
    chk("busy_after_three", 64'(busy), 64'h0);

    // overflow while the line is busy: 4 accepted, 5th dropped
    cyc(1, 0, 2'd0, 8'h11);
    idle(2);
    for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, 8'(8'h21 + i));
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_overflow", 64'(io_rdata), 64'h04D);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_overflow_cleared", 64'(io_rdata), 64'h045);
    idle(5 * (FRAME + 1) + 10);

    // full FIFO, write landing on the IDLE pop cycle is accepted
    cyc(1, 0, 2'd0, 8'h30);
    for (int i = 1; i < 5; i++) cyc(1, 0, 2'd0, 8'(8'h30 + i));
    chk("model_full", 64'(mq.size()), 64'd4);
    n = 0;
    while (mpos >= 0 && n < 200) begin
      step();
      n++;
    end
    chk("reach_pop_cycle", 64'(n < 200), 64'd1);
    cyc(1, 0, 2'd0, 8'h3C);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_pop_push", 64'(io_rdata), 64'h045);
    idle(5 * (FRAME + 1) + 10);

    // reset in the middle of data bit 3, second byte queued
    cyc(1, 0, 2'd0, 8'hB7);
    cyc(1, 0, 2'd0, 8'hC8);
    n = 0;
    while (mpos != 4 * BAUD + 1 && n < 200) begin
      step();
      n++;
    end
    chk("reach_bit3", 64'(n < 200), 64'd1);
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("tx_after_reset", 64'(tx), 64'h1);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_after_reset", 64'(io_rdata), 64'h002);
    n = cap_q.size();
    idle(60);
    chk("no_resume_after_reset", 64'(cap_q.size()), 64'(n));
    chk("idle_after_reset", 64'(busy), 64'h0);

    // simultaneous read and write
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_before_combo", 64'(io_rdata), 64'h002);
    cyc(1, 1, 2'd0, 8'h5A);
    chk("combo_read_data", 64'(io_rdata), 64'h0);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_after_combo", 64'(io_rdata), 64'h010);
    cyc(0, 1, 2'd1, 8'h00);
    chk("status_shifting", 64'(io_rdata), 64'h006);
    idle(FRAME + 10);

    // everything that reached the line, in order
    chk("frame_count", 64'(cap_q.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < cap_q.size()) begin
        chk($sformatf("rx_byte_%0d", i), 64'(decode(cap_q[i])), 64'(exp_bytes[i]));
        chk($sformatf("stop_bit_%0d", i), 64'(cap_q[i][FRAME-1]), 64'h1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
